// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative 32-bit normalizer. It shifts the operand one bit
// per cycle until the selected normalization condition holds, then reports the
// normalized word and the number of shifts applied. Feeding result/shiftamt
// back through the combinational Shifter with the inverse op restores the operand.
module shift_normalizer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value_in,
    input  logic [1:0]  normop,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  shiftamt,
    output logic        zero,
    output logic        err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_RIGHT  = 2'b00;
    localparam logic [1:0] OP_SIGNED = 2'b01;
    localparam logic [1:0] OP_LEFT   = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  amt_q, amt_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] shifted_s;
    logic        term_s;

    // One-bit step and termination test for the latched operation.
    always_comb begin
        shifted_s = work_q;
        term_s    = 1'b1;
        case (op_q)
            OP_LEFT: begin
                shifted_s = {work_q[30:0], 1'b0};
                term_s    = work_q[31];
            end
            OP_RIGHT: begin
                shifted_s = {1'b0, work_q[31:1]};
                term_s    = work_q[0];
            end
            OP_SIGNED: begin
                // Left shift until the sign bit differs from the next bit;
                // all-ones is not a zero case and ends at 0x80000000.
                shifted_s = {work_q[30:0], 1'b0};
                term_s    = work_q[31] ^ work_q[30];
            end
            default: begin
                shifted_s = work_q;
                term_s    = 1'b1;
            end
        endcase
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        amt_d   = amt_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = value_in;
                    op_d    = normop;
                    amt_d   = 5'd0;
                    zero_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (work_q == 32'd0) begin
                    // Nothing to normalize; a reserved op is still flagged.
                    zero_d  = 1'b1;
                    err_d   = (op_q == OP_RSVD);
                    amt_d   = 5'd0;
                    state_d = ST_DONE;
                end else if (op_q == OP_RSVD) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (term_s) begin
                    state_d = ST_DONE;
                end else begin
                    // A nonzero operand terminates within 31 shifts, so the
                    // 5-bit count never wraps.
                    work_d = shifted_s;
                    amt_d  = amt_q + 5'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset; a reset mid-job
    // aborts it without producing done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= 32'd0;
            op_q    <= 2'b00;
            amt_q   <= 5'd0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = work_q;
    assign shiftamt = amt_q;
    assign zero     = zero_q;
    assign err      = err_q;

endmodule
